// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared definitions for the load/store stage:
//     - RV32I funct3 width/sign codes for loads and stores
//     - access state encoding
//     - ZERO/ONE single-bit constants
//     - access_fault(): decides whether an access is illegal or misaligned
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2,
        ST_FIN  = 2'd3
    } lsu_state_e;

    // An access faults when its funct3 is not a legal load/store code or when
    // the address is not naturally aligned to the access size. funct3[1:0]
    // gives the size for every legal code (00 byte, 01 half, 10 word).
    function automatic logic access_fault(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic illegal;
        logic misalign;
        if (is_load) begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else begin
            illegal = f3[2] || (f3[1:0] == 2'b11);
        end
        case (f3[1:0])
            2'b01:   misalign = addr_lo[0];
            2'b10:   misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase
        return illegal || misalign;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Combinational load-data extraction: picks the addressed byte/halfword out
//   of the memory word and sign- or zero-extends it to n bits.
//   Ports:
//     funct3  in  3  load width/sign code
//     addr    in  2  byte offset within the word
//     rdata   in  n  word returned by memory
//     result  out n  extended load value
//   Only n=32 is meaningful.
// -----------------------------------------------------------------------------
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr,
    input  logic [n-1:0] rdata,
    output logic [n-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = rdata[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{(n-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(n-16){half_sel[15]}}, half_sel};
            F3_LBU:  result = {{(n-8){ZERO}}, byte_sel};
            F3_LHU:  result = {{(n-16){ZERO}}, half_sel};
            default: result = rdata;   // LW
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Multi-cycle data-memory access stage. Accepts an access when idle, runs one
//   req/ack transaction on the memory port with byte-lane steering, and for
//   loads writes the extended result to the register file for one cycle.
//   Ports:
//     clk, rst (async, active-low)
//     start/is_load/funct3/addr/store_data/rd   access request (sampled on start)
//     busy, done, fault                          status
//     mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory request side
//     mem_ack/mem_rdata                          memory response side
//     rf_write/rf_write_reg/rf_write_data        register-file write port
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_load,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] store_data,
    input  logic [4:0]   rd,
    output logic         busy,
    output logic         done,
    output logic         fault,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    output logic [3:0]   mem_be,
    input  logic         mem_ack,
    input  logic [n-1:0] mem_rdata,
    output logic         rf_write,
    output logic [4:0]   rf_write_reg,
    output logic [n-1:0] rf_write_data
);

    lsu_state_e   state_q,     state_d;
    logic         fault_q,     fault_d;
    logic         is_load_q,   is_load_d;
    logic [2:0]   funct3_q,    funct3_d;
    logic [1:0]   addr_lo_q,   addr_lo_d;
    logic [4:0]   rd_q,        rd_d;
    logic [n-1:0] mem_addr_q,  mem_addr_d;
    logic         mem_we_q,    mem_we_d;
    logic [3:0]   mem_be_q,    mem_be_d;
    logic [n-1:0] mem_wdata_q, mem_wdata_d;
    logic [n-1:0] rdata_q,     rdata_d;

    logic         fault_cond;
    logic [n-1:0] ext_result;

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        fault_cond  = access_fault(is_load, funct3, addr[1:0]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fault_d    = fault_cond;
                    is_load_d  = is_load;
                    funct3_d   = funct3;
                    addr_lo_d  = addr[1:0];
                    rd_d       = rd;
                    mem_addr_d = {addr[n-1:2], 2'b00};
                    // Store lane steering is precomputed here so the memory
                    // port sees registered, stable values for the whole request.
                    if (is_load) begin
                        mem_we_d    = ZERO;
                        mem_be_d    = 4'b1111;
                        mem_wdata_d = store_data;
                    end else begin
                        mem_we_d = !fault_cond;
                        case (funct3)
                            F3_SB: begin
                                mem_be_d    = 4'b0001 << addr[1:0];
                                mem_wdata_d = {4{store_data[7:0]}};
                            end
                            F3_SH: begin
                                mem_be_d    = 4'b0011 << {addr[1], 1'b0};
                                mem_wdata_d = {2{store_data[15:0]}};
                            end
                            default: begin
                                mem_be_d    = 4'b1111;
                                mem_wdata_d = store_data;
                            end
                        endcase
                    end
                    state_d = fault_cond ? ST_FIN : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (is_load_q) begin
                        rdata_d = mem_rdata;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_WB:   state_d = ST_IDLE;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fault_q     <= ZERO;
            is_load_q   <= ZERO;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= ZERO;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Extension works on the captured word so the write-back value does not
    // depend on mem_rdata after the ack cycle.
    load_extend #(.n(n)) u_load_extend (
        .funct3 (funct3_q),
        .addr   (addr_lo_q),
        .rdata  (rdata_q),
        .result (ext_result)
    );

    // Outputs decode straight from the state register, so an asynchronous
    // reset clears them immediately.
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_WB) || (state_q == ST_FIN);
    assign fault         = (state_q == ST_FIN) && fault_q;
    assign mem_req       = (state_q == ST_REQ);
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    // x0 is hard-wired to zero, so a load into rd=0 completes without a write.
    assign rf_write      = (state_q == ST_WB) && (rd_q != 5'd0);
    assign rf_write_reg  = rd_q;
    assign rf_write_data = ext_result;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage between execute and register-file write-back in the RISCV_Processor datapath.
- Takes the effective address, the store data (register-file read_data2) and the destination register.
- Runs a req/ack transaction on the data-memory port and performs byte-lane steering plus sign/zero extension.
- For loads, drives the register file's write, write_reg and write_data for exactly one cycle.

Parameters:
- n, 32, datapath width. Lane logic is defined only for n=32; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin an access; accepted only when busy=0
- is_load  input  1  1=load, 0=store; sampled with start
- funct3  input  3  RV32I width/sign code; sampled with start
- addr  input  n  effective byte address; sampled with start
- store_data  input  n  store source (rs2); sampled with start
- rd  input  5  load destination; sampled with start
- busy  output  1  high from the cycle after an accepted start until the cycle after done
- done  output  1  one-cycle completion pulse
- fault  output  1  one-cycle pulse coincident with done on misaligned or illegal access
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  memory write enable
- mem_addr  output  n  word address {addr[n-1:2],2'b00}
- mem_wdata  output  n  lane-replicated store data
- mem_be  output  4  byte enables
- mem_ack  input  1  memory completion, may arrive in the first mem_req cycle
- mem_rdata  input  n  read word, valid while mem_ack=1
- rf_write  output  1  register-file write strobe
- rf_write_reg  output  5  register-file destination
- rf_write_data  output  n  extended load result

Behaviour:
- Reset (rst=0, async): state IDLE. busy, done, fault, mem_req, mem_we and rf_write are all 0. mem_be=0; all data and address outputs are 0. An in-flight access is abandoned with no rf_write. A late mem_ack after reset release is ignored in IDLE.
- States: IDLE, REQ, WB, FIN.
- IDLE, start=1: latch all inputs.
  - Illegal funct3 → FAULT condition. Illegal means loads 011/110/111 and stores other than 000/001/010.
  - Misalignment → FAULT condition: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - FAULT condition → go to FIN with fault=1, and never assert mem_req.
  - Otherwise → go to REQ.
- REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are stable until ack.
  - On mem_ack, a load latches mem_rdata and goes to WB; a store goes to FIN.
  - mem_req deasserts in the cycle after ack.
- WB (loads only): rf_write=1 for one cycle, with rf_write_reg=rd and rf_write_data=extended value; done=1 in the same cycle. Return to IDLE.
  - rd=0: rf_write stays 0; done still pulses.
- FIN: done=1, plus fault if flagged, for one cycle. Return to IDLE.
- Latency: start in cycle 0 → mem_req in cycle 1 → ack in cycle k≥1 → done in cycle k+1. A faulted access gives done in cycle 1.
- start while busy: ignored, not queued. The cycle after done may accept a new start.
- Store lanes:
  - SB: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{data[7:0]}}.
  - SH: mem_be = 4'b0011 << {addr[1],1'b0}; mem_wdata = {2{data[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = data.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - Loads drive mem_be=4'b1111.

Decomposition:
- The shared defines file holds:
  - funct3 encodings: LB/LH/LW/LBU/LHU/SB/SH/SW;
  - state encodings;
  - the existing ZERO/ONE constants.
- One combinational sub-module, load_extend, with inputs funct3, addr[1:0] and rdata, and output the extended n-bit result.
- Store steering stays inline.

Test Plan:
- LB, addr=0x1003, ack after 2 wait cycles, mem_rdata=0x80FF1234, rd=5:
  - mem_addr=0x1000 and mem_we=0;
  - one rf_write with rf_write_reg=5 and rf_write_data=0xFFFFFF80;
  - done coincident with rf_write;
  - busy high throughout the access.
- LHU, addr=0x1002, same-cycle ack, mem_rdata=0x80FF1234, rd=7: rf_write_data=0x000080FF; done 2 cycles after start.
- SB, addr=0x2001, store_data=0x123456AB:
  - mem_we=1, mem_be=4'b0010, mem_wdata=0xABABABAB until ack;
  - rf_write never asserts.
- LW at addr=0x1002, then a separate load with funct3=3'b011: each gives fault=1 and done=1 one cycle after start, no mem_req, no rf_write.
- LW with rd=0 and mem_rdata=0xDEADBEEF: done pulses and rf_write stays 0. A start pulsed during busy is ignored: exactly one mem_req transaction occurs.
- Reset mid-REQ:
  - drop rst while mem_req=1: mem_req, busy and rf_write go 0 immediately, without waiting for a clock edge;
  - a mem_ack after rst returns high produces no rf_write and no done.
